// File: rtl/vga_qsys_if.sv
// ----------------------------------------------------------------------------
// vga_qsys_if
//  Bundles the video-side outputs of the VGA engine that go to the ADV7123 DAC
//  and the VGA connector.
//
//  Signals
//   o_VGA_clk    1  pixel clock to the DAC (half of the system clock)
//   o_VGA_HS     1  horizontal sync, active-low
//   o_VGA_VS     1  vertical sync, active-low
//   o_VGA_blank  1  blank_n, high during active video
//   o_VGA_sync   1  sync_n to the DAC, held low
//   o_VGA_R/G/B  8  colour channels
//
//  Modports
//   master  the engine that drives the video signals
//   slave   a consumer (DAC model, monitor, testbench)
// ----------------------------------------------------------------------------
interface vga_qsys_if;
  logic       o_VGA_clk;
  logic       o_VGA_HS;
  logic       o_VGA_VS;
  logic       o_VGA_blank;
  logic       o_VGA_sync;
  logic [7:0] o_VGA_R;
  logic [7:0] o_VGA_G;
  logic [7:0] o_VGA_B;

  modport master (
    output o_VGA_clk, o_VGA_HS, o_VGA_VS, o_VGA_blank, o_VGA_sync,
    output o_VGA_R, o_VGA_G, o_VGA_B
  );

  modport slave (
    input o_VGA_clk, o_VGA_HS, o_VGA_VS, o_VGA_blank, o_VGA_sync,
    input o_VGA_R, o_VGA_G, o_VGA_B
  );
endinterface

// File: rtl/vga_qsys.sv
// ----------------------------------------------------------------------------
// vga_qsys
//  Self-contained VGA display engine. Divides the system clock by two to make
//  the pixel clock, generates 640x480@60Hz sync/blank timing and paints one of
//  three built-in test patterns (colour bars, gradient, 32x32 checker). The
//  active-low start button starts the display from IDLE; further presses cycle
//  the pattern without disturbing the timing.
//
//  Ports
//   clk_clk      in   1  system clock (50 MHz), all logic on the rising edge
//   reset_reset  in   1  synchronous, active-high reset
//   i_start      in   1  start/mode button, active-low, asynchronous
//   vga          master  video outputs (see vga_qsys_if)
//
//  Timing
//   Every video output is registered on a pixel-enable cycle from the counter
//   values present on that cycle, so the outputs show pixel (h,v) one pixel
//   period after the counters held (h,v); HS, VS, blank and RGB stay aligned.
// ----------------------------------------------------------------------------
module vga_qsys #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       i_start,
  vga_qsys_if.master vga
);

  typedef logic [9:0] cnt_t;

  localparam cnt_t H_LAST   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t H_VIS    = cnt_t'(H_ACTIVE);
  localparam cnt_t V_VIS    = cnt_t'(V_ACTIVE);
  localparam cnt_t HS_FIRST = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HS_LAST  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VS_FIRST = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VS_LAST  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam int   BAR_W    = H_ACTIVE / 8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    M_BARS  = 2'd0,
    M_GRAD  = 2'd1,
    M_CHECK = 2'd2
  } mode_e;

  // Clock divider
  logic        pix_en_q;
  logic        vga_clk_q;

  // Button synchronizer and edge detector
  logic        sync1_q;
  logic        sync2_q;
  logic        sync3_q;
  logic        press;

  // Control
  state_e      state_q, state_d;
  mode_e       mode_q,  mode_d;

  // Raster counters
  cnt_t        h_cnt_q, h_cnt_d;
  cnt_t        v_cnt_q, v_cnt_d;

  // Registered video outputs
  logic        hs_q,    hs_d;
  logic        vs_q,    vs_d;
  logic        blank_q, blank_d;
  logic [23:0] rgb_q,   rgb_d;

  // Pattern generation
  logic [2:0]  bar_idx;
  logic [23:0] pattern;
  logic        active;

  // sync1/sync2 resolve metastability; sync3 holds the previous settled level
  // so that a press is one pulse on the settled 1->0 transition, however long
  // the button is held.
  assign press = sync3_q & ~sync2_q;

  // --------------------------------------------------------------------------
  // Control FSM: IDLE waits for the first press, RUN cycles the pattern mode.
  // --------------------------------------------------------------------------
  // NOTE: every signal driven in an always_comb gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (press) state_d = S_RUN;
      end
      S_RUN: begin
        if (press) begin
          case (mode_q)
            M_BARS:  mode_d = M_GRAD;
            M_GRAD:  mode_d = M_CHECK;
            default: mode_d = M_BARS;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Raster counters: held at the origin in IDLE, so the first RUN pixel is
  // (0,0); otherwise advance once per pixel period.
  // --------------------------------------------------------------------------
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (state_q == S_IDLE) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (pix_en_q) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Test patterns for the pixel currently addressed by the counters.
  // --------------------------------------------------------------------------
  always_comb begin
    // Bar index by threshold comparison: avoids a divider for h / BAR_W.
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (h_cnt_q >= cnt_t'(i * BAR_W)) bar_idx = 3'(i);
    end

    pattern = 24'h000000;
    case (mode_q)
      M_BARS: begin
        case (bar_idx)
          3'd0:    pattern = 24'hFFFFFF;  // white
          3'd1:    pattern = 24'hFFFF00;  // yellow
          3'd2:    pattern = 24'h00FFFF;  // cyan
          3'd3:    pattern = 24'h00FF00;  // green
          3'd4:    pattern = 24'hFF00FF;  // magenta
          3'd5:    pattern = 24'hFF0000;  // red
          3'd6:    pattern = 24'h0000FF;  // blue
          default: pattern = 24'h000000;  // black
        endcase
      end
      M_GRAD:  pattern = {h_cnt_q[7:0], v_cnt_q[7:0], 8'h80};
      M_CHECK: pattern = (h_cnt_q[5] ^ v_cnt_q[5]) ? 24'hFFFFFF : 24'h000000;
      default: pattern = 24'h000000;
    endcase
  end

  // --------------------------------------------------------------------------
  // Video outputs: idle values in IDLE, otherwise sampled once per pixel.
  // --------------------------------------------------------------------------
  always_comb begin
    hs_d    = hs_q;
    vs_d    = vs_q;
    blank_d = blank_q;
    rgb_d   = rgb_q;
    active  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    if (state_q == S_IDLE) begin
      hs_d    = 1'b1;
      vs_d    = 1'b1;
      blank_d = 1'b0;
      rgb_d   = '0;
    end else if (pix_en_q) begin
      hs_d    = ~((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
      vs_d    = ~((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
      blank_d = active;
      rgb_d   = active ? pattern : 24'h000000;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pix_en_q  <= 1'b0;
      vga_clk_q <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync3_q   <= 1'b1;
      state_q   <= S_IDLE;
      mode_q    <= M_BARS;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      pix_en_q  <= ~pix_en_q;
      vga_clk_q <= pix_en_q;
      sync1_q   <= i_start;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
      state_q   <= state_d;
      mode_q    <= mode_d;
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_q   <= blank_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga.o_VGA_clk   = vga_clk_q;
  assign vga.o_VGA_HS    = hs_q;
  assign vga.o_VGA_VS    = vs_q;
  assign vga.o_VGA_blank = blank_q;
  assign vga.o_VGA_sync  = 1'b0;
  assign vga.o_VGA_R     = rgb_q[23:16];
  assign vga.o_VGA_G     = rgb_q[15:8];
  assign vga.o_VGA_B     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_qsys.sv
// ----------------------------------------------------------------------------
// tb_vga_qsys
//  Self-checking bench for vga_qsys. Horizontal timing is the real 800-pixel
//  line; the vertical timing is shortened to a 10-line frame (6 visible) so a
//  whole frame, including the VS pulse, fits in a short run.
//  A reference model derives every output from the pixel number since start
//  (h = p mod 800, v = p div 800 mod 10) and from the press history; a compare
//  process checks the DUT against it on every cycle, and literal expectations
//  at chosen pixels pin both the DUT and the model.
// ----------------------------------------------------------------------------
module tb_vga_qsys;

  localparam int H_ACT  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int HT     = H_ACT + H_FP + H_SYNC + H_BP;   // 800
  localparam int V_ACT  = 6;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;   // 10
  localparam int BOUND  = 20000;                          // > one frame of clocks

  logic clk = 1'b0;
  logic rst;
  logic start_n;

  int   total = 0;
  int   bad   = 0;
  bit   check_en = 1'b0;

  vga_qsys_if vga ();

  vga_qsys #(
    .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .i_start    (start_n),
    .vga        (vga)
  );

  always #10 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  int          m_edge;    // clock edges since reset released
  bit          m_run;
  int          m_mode;
  int          m_pix;     // pixels drawn since the display started
  bit [2:0]    m_hist;    // button level seen at the last three edges, [0] newest
  bit          m_clk, m_hs, m_vs, m_blank, m_shown;
  logic [23:0] m_rgb;
  int          m_h, m_v;

  function automatic logic [23:0] colour(input int h, input int v, input int mode);
    logic [7:0] h8;
    logic [7:0] v8;
    h8 = 8'(h % 256);
    v8 = 8'(v % 256);
    if (h >= H_ACT || v >= V_ACT) return 24'h000000;
    case (mode)
      0:       return bars[h / (H_ACT / 8)];
      1:       return {h8, v8, 8'h80};
      default: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // A falling button level acts three edges after it is first sampled:
  // two synchronizer stages plus the registered control state.
  always @(posedge clk) begin
    bit press;
    if (rst) begin
      m_edge = 0; m_run = 1'b0; m_mode = 0; m_pix = 0; m_hist = 3'b111;
      m_clk = 1'b0; m_hs = 1'b1; m_vs = 1'b1; m_blank = 1'b0; m_rgb = '0;
      m_shown = 1'b0; m_h = 0; m_v = 0;
    end else begin
      press  = !m_hist[1] && m_hist[2];
      m_hist = {m_hist[1:0], start_n};
      m_edge++;
      m_clk  = (m_edge % 2 == 0);
      if (m_run && m_clk) begin
        m_h     = m_pix % HT;
        m_v     = (m_pix / HT) % VT;
        m_hs    = !(m_h >= H_ACT + H_FP && m_h < H_ACT + H_FP + H_SYNC);
        m_vs    = !(m_v >= V_ACT + V_FP && m_v < V_ACT + V_FP + V_SYNC);
        m_blank = (m_h < H_ACT) && (m_v < V_ACT);
        m_rgb   = colour(m_h, m_v, m_mode);
        m_shown = 1'b1;
        m_pix++;
      end
      if (press) begin
        if (!m_run) begin
          m_run = 1'b1;
          m_pix = 0;
        end else begin
          m_mode = (m_mode + 1) % 3;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      total++;
      if ({vga.o_VGA_clk, vga.o_VGA_HS, vga.o_VGA_VS, vga.o_VGA_blank, vga.o_VGA_sync,
           vga.o_VGA_R, vga.o_VGA_G, vga.o_VGA_B} !==
          {m_clk, m_hs, m_vs, m_blank, 1'b0, m_rgb}) begin
        bad++;
        $display("FAIL cycle t=%0t: dut clk/hs/vs/blank/sync=%b%b%b%b%b rgb=%02h%02h%02h, model %b%b%b%b0 rgb=%06h (h=%0d v=%0d)",
                 $time, vga.o_VGA_clk, vga.o_VGA_HS, vga.o_VGA_VS, vga.o_VGA_blank,
                 vga.o_VGA_sync, vga.o_VGA_R, vga.o_VGA_G, vga.o_VGA_B,
                 m_clk, m_hs, m_vs, m_blank, m_rgb, m_h, m_v);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    check({name, " HS"},    32'(vga.o_VGA_HS),    32'd1);
    check({name, " VS"},    32'(vga.o_VGA_VS),    32'd1);
    check({name, " blank"}, 32'(vga.o_VGA_blank), 32'd0);
    check({name, " sync"},  32'(vga.o_VGA_sync),  32'd0);
    check({name, " rgb"},   32'({vga.o_VGA_R, vga.o_VGA_G, vga.o_VGA_B}), 32'd0);
  endtask

  task automatic check_pix(input string name, input logic [23:0] exp_rgb, input logic exp_blank);
    check({name, " dut rgb"},   32'({vga.o_VGA_R, vga.o_VGA_G, vga.o_VGA_B}), 32'(exp_rgb));
    check({name, " model rgb"}, 32'(m_rgb), 32'(exp_rgb));
    check({name, " blank"},     32'(vga.o_VGA_blank), 32'(exp_blank));
  endtask

  task automatic wait_pixel(input int h, input int v);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < BOUND && !ok; i++) begin
      @(negedge clk);
      if (m_shown && m_h == h && m_v == v) ok = 1'b1;
    end
    check($sformatf("reach pixel %0d,%0d", h, v), 32'(ok), 32'd1);
  endtask

  task automatic window(input int n, output int hs_lo, output int vs_lo, output int bl_hi);
    hs_lo = 0; vs_lo = 0; bl_hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (vga.o_VGA_HS === 1'b0)    hs_lo++;
      if (vga.o_VGA_VS === 1'b0)    vs_lo++;
      if (vga.o_VGA_blank === 1'b1) bl_hi++;
    end
  endtask

  // One press with a randomized hold time, then released.
  task automatic press();
    start_n = 1'b0;
    repeat ($urandom_range(20, 6)) @(negedge clk);
    start_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int hs_lo, vs_lo, bl_hi;
    rst     = 1'b1;
    start_n = 1'b1;
    @(negedge clk);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset vga_clk", 32'(vga.o_VGA_clk), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("vga_clk toggle", 32'(vga.o_VGA_clk), 32'(i % 2));
    end

    window(2000, hs_lo, vs_lo, bl_hi);
    check("idle HS low clocks", 32'(hs_lo), 32'd0);
    check("idle VS low clocks", 32'(vs_lo), 32'd0);
    check("idle blank clocks",  32'(bl_hi), 32'd0);
    check_idle("idle");

    // Start and keep the button held across the first line: counts once.
    start_n = 1'b0;
    wait_pixel(0, 0);    check_pix("mode0 h=0",   24'hFFFFFF, 1'b1);
    check("first pixel HS", 32'(vga.o_VGA_HS), 32'd1);
    wait_pixel(79, 0);   check_pix("mode0 h=79",  24'hFFFFFF, 1'b1);
    wait_pixel(80, 0);   check_pix("mode0 h=80",  24'hFFFF00, 1'b1);
    wait_pixel(639, 0);  check_pix("mode0 h=639", 24'h000000, 1'b1);
    wait_pixel(640, 0);  check_pix("mode0 h=640", 24'h000000, 1'b0);
    start_n = 1'b1;

    window(2 * HT, hs_lo, vs_lo, bl_hi);
    check("HS low clocks per line", 32'(hs_lo), 32'd192);
    window(2 * HT * VT, hs_lo, vs_lo, bl_hi);
    check("HS low clocks per frame",    32'(hs_lo), 32'd1920);
    check("VS low clocks per frame",    32'(vs_lo), 32'd3200);
    check("blank high clocks per frame", 32'(bl_hi), 32'd7680);

    press();
    wait_pixel(10, 3);   check_pix("mode1 10,3",  24'h0A0380, 1'b1);
    press();
    wait_pixel(32, 4);   check_pix("mode2 32,4",  24'hFFFFFF, 1'b1);
    wait_pixel(64, 4);   check_pix("mode2 64,4",  24'h000000, 1'b1);
    wait_pixel(0, 5);    check_pix("mode2 0,5",   24'h000000, 1'b1);
    press();
    wait_pixel(85, 5);   check_pix("mode0 again 85,5", 24'hFFFF00, 1'b1);
    press();
    wait_pixel(200, 5);  check_pix("mode1 200,5", 24'hC80580, 1'b1);

    // Reset mid-line while showing mode1.
    wait_pixel(300 + $urandom_range(40, 0), 5);
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid-line reset");
    check("mid-line reset vga_clk", 32'(vga.o_VGA_clk), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_idle("after reset");

    // Restart: origin and mode0 again.
    start_n = 1'b0;
    wait_pixel(0, 0);    check_pix("restart 0,0",  24'hFFFFFF, 1'b1);
    wait_pixel(80, 0);   check_pix("restart 80,0", 24'hFFFF00, 1'b1);
    start_n = 1'b1;
    repeat (2000) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
